axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-master AXI4 read-channel arbiter between the instruction-cache AXI engine (icache fills and uncached fetches) and the data-cache AXI engine, driving the single CPU AXI read port. Round-robin grant, one outstanding read burst at a time, with the burst locked to its owner from AR acceptance until the RLAST beat. It sits between the cache AXI engines and the top-level AXI interface. The write channels bypass this block.

## Interface
- ICACHE_ID, 4'd0: ARID driven for icache-owned bursts
- DCACHE_ID, 4'd1: ARID driven for dcache-owned bursts
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- i_arvalid  in  1  icache read request
- i_araddr  in  32  icache request address
- i_arlen  in  4  icache burst length minus 1
- i_arready  out  1  icache request accepted this cycle
- i_rvalid  out  1  R beat for icache
- d_arvalid  in  1  dcache read request
- d_araddr  in  32  dcache request address
- d_arlen  in  4  dcache burst length minus 1
- d_arready  out  1  dcache request accepted this cycle
- d_rvalid  out  1  R beat for dcache
- s_rdata  out  32  m_rdata broadcast to both engines
- s_rlast  out  1  m_rlast broadcast to both engines
- m_arid  out  4  owner ID
- m_araddr  out  32  latched address
- m_arlen  out  4  latched length
- m_arsize  out  3  constant 3'b010
- m_arburst  out  2  constant 2'b01 (INCR)
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rdata  in  32  R data
- m_rlast  in  1  R last
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- owner  out  2  one-hot {dcache, icache} burst owner; 2'b00 when idle

## Operation
- FSM states: IDLE, ADDR, DATA. Reset state is IDLE.
- Registers: last_grant (reset: icache), owner, addr_q, len_q.
- IDLE with no request: stay in IDLE.
- IDLE with exactly one request: grant that requester.
- IDLE with both requests: grant the requester that is not last_grant. After reset, dcache wins the first tie.
- On a grant in IDLE:
  - pulse the granted requester's x_arready for one cycle;
  - latch its addr and len into addr_q/len_q;
  - set owner and last_grant to the granted requester;
  - go to ADDR.
- Engines must hold arvalid/addr/len stable until they see arready. They drop arvalid the cycle after the arready pulse.
- ADDR: m_arvalid=1, and m_araddr/m_arlen/m_arid come from the latched registers. On m_arvalid & m_arready, go to DATA.
- DATA: m_rready=1. Each m_rvalid beat drives the owner's x_rvalid for the same cycle. The non-owner's rvalid stays 0. Engines always accept beats.
- DATA, on m_rvalid & m_rlast: go to IDLE and clear owner.
- The beat count is not checked; rlast alone ends the burst.
- Outside DATA: m_rready=0, i_rvalid=0, d_rvalid=0.
- Outside ADDR: m_arvalid=0.
- m_araddr/m_arlen/m_arid show the latched values in every state, including IDLE (0 after reset).

## Timing
- Reset values:
  - state IDLE, owner 2'b00;
  - m_arvalid 0, m_rready 0, i_arready 0, d_arready 0, i_rvalid 0, d_rvalid 0;
  - m_araddr 0, m_arlen 0, m_arid 0;
  - last_grant icache.
- Outputs are registered from state and owner; only x_rvalid/s_rdata/s_rlast are combinational from the m_r* inputs.
- Latency: request seen in IDLE at cycle N → x_arready at N, m_arvalid at N+1.
- AR handshake at cycle N+k → m_rready from N+k+1.
- After the RLAST beat at cycle M, state is IDLE at M+1, and the next grant can occur in that same cycle M+1.
- A request arriving during ADDR/DATA waits. The tie is resolved by round-robin at the next IDLE.
- Reset asserted mid-burst returns every output to its reset value immediately. The interconnect is reset by the same aresetn.

## Test plan
- icache only, addr 0x1FC0_0000, len 7 → i_arready pulse; m_arvalid next cycle with arid 0, arlen 7; 8 beats on i_rvalid only, d_rvalid stays 0; IDLE after rlast.
- Both request in the same cycle right after reset → dcache granted first (arid 1). After its rlast, icache is granted with no idle cycle between the rlast cycle+1 and the grant.
- Continuous requests from both for 4 bursts → grants alternate d, i, d, i.
- m_arready held low for 5 cycles → m_arvalid and m_araddr stay stable; no R routing until the handshake.
- dcache single beat (len 0, addr 0xBFAF_0000) with rvalid gaps → d_rvalid mirrors m_rvalid exactly; owner 2'b10 throughout; 2'b00 after rlast.
- aresetn pulsed low on the 3rd beat of an icache burst → all outputs at reset values; a new request after release is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter: round-robin between the icache and dcache engines,
// one burst in flight, owner locked from the AR grant until the RLAST beat.
module axi_rd_arbiter #(
   parameter logic [3:0] ICACHE_ID = 4'd0,
   parameter logic [3:0] DCACHE_ID = 4'd1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        i_arvalid,
   input  logic [31:0] i_araddr,
   input  logic [3:0]  i_arlen,
   output logic        i_arready,
   output logic        i_rvalid,
   input  logic        d_arvalid,
   input  logic [31:0] d_araddr,
   input  logic [3:0]  d_arlen,
   output logic        d_arready,
   output logic        d_rvalid,
   output logic [31:0] s_rdata,
   output logic        s_rlast,
   output logic [3:0]  m_arid,
   output logic [31:0] m_araddr,
   output logic [3:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic        m_rlast,
   input  logic        m_rvalid,
   output logic        m_rready,
   output logic [1:0]  owner
);
   // Handshakes: a transfer happens on any cycle where valid and ready are both high;
   // x_arready is a one-cycle grant pulse, and R beats are always accepted by the engines.
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   logic        last_dc_q, last_dc_d;   // 1 when dcache won the most recent grant
   logic [31:0] addr_q, addr_d;
   logic [3:0]  len_q, len_d;
   logic [3:0]  id_q, id_d;
   logic        grant_ic, grant_dc;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         owner_q   <= 2'b00;
         last_dc_q <= 1'b0;
         addr_q    <= 32'd0;
         len_q     <= 4'd0;
         id_q      <= 4'd0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_dc_q <= last_dc_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         id_q      <= id_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_dc_d = last_dc_q;
      addr_d    = addr_q;
      len_d     = len_q;
      id_d      = id_q;
      grant_ic  = 1'b0;
      grant_dc  = 1'b0;
      case (state_q)
         IDLE: begin
            // On a tie the requester that did not win last time gets the bus.
            if (aresetn && i_arvalid && (!d_arvalid || last_dc_q)) begin
               grant_ic = 1'b1;
            end else if (aresetn && d_arvalid) begin
               grant_dc = 1'b1;
            end
            if (grant_ic) begin
               addr_d    = i_araddr;
               len_d     = i_arlen;
               id_d      = ICACHE_ID;
               owner_d   = 2'b01;
               last_dc_d = 1'b0;
               state_d   = ADDR;
            end else if (grant_dc) begin
               addr_d    = d_araddr;
               len_d     = d_arlen;
               id_d      = DCACHE_ID;
               owner_d   = 2'b10;
               last_dc_d = 1'b1;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (m_arready) state_d = DATA;
         end
         DATA: begin
            // Only RLAST ends the burst; beats are not counted against len_q.
            if (m_rvalid && m_rlast) begin
               state_d = IDLE;
               owner_d = 2'b00;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign i_arready = grant_ic;
   assign d_arready = grant_dc;
   assign m_arvalid = (state_q == ADDR);
   assign m_rready  = (state_q == DATA);
   assign i_rvalid  = (state_q == DATA) && owner_q[0] && m_rvalid;
   assign d_rvalid  = (state_q == DATA) && owner_q[1] && m_rvalid;
   assign s_rdata   = m_rdata;
   assign s_rlast   = m_rlast;
   assign m_arid    = id_q;
   assign m_araddr  = addr_q;
   assign m_arlen   = len_q;
   assign m_arsize  = 3'b010;
   assign m_arburst = 2'b01;
   assign owner     = owner_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: two request engines and a memory responder drive the arbiter;
// a transaction-level model predicts grants, AR contents and R routing each cycle.
module tb_axi_rd_arbiter;
   localparam logic [3:0] ICACHE_ID = 4'd0;
   localparam logic [3:0] DCACHE_ID = 4'd1;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        i_arvalid, d_arvalid, i_arready, d_arready, i_rvalid, d_rvalid;
   logic [31:0] i_araddr, d_araddr, s_rdata, m_araddr, m_rdata;
   logic [3:0]  i_arlen, d_arlen, m_arid, m_arlen;
   logic        s_rlast, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst, owner;

   always #5 aclk = ~aclk;

   axi_rd_arbiter #(.ICACHE_ID(ICACHE_ID), .DCACHE_ID(DCACHE_ID)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen),
      .i_arready(i_arready), .i_rvalid(i_rvalid),
      .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen),
      .d_arready(d_arready), .d_rvalid(d_rvalid),
      .s_rdata(s_rdata), .s_rlast(s_rlast),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .owner(owner)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  len;
   } req_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard and stimulus state
   req_t        i_req_q[$];
   req_t        d_req_q[$];
   logic [39:0] exp_q[$];          // {id, len, addr} of each grant awaiting its AR handshake
   int          grant_log[$];      // 0 = icache, 1 = dcache
   bit          i_pres, d_pres, i_cool, d_cool;
   bit          sl_data;
   int          sl_beats, sl_idx, sl_wait;
   int          ar_delay = 0;
   int          rv_pct   = 100;
   bit          junk_en  = 1'b0;
   bit          rnd_mode = 1'b0;
   bit          rst_beat = 1'b0;
   bit          rst_fired = 1'b0;
   int          obs_i, obs_d, obs_arv;

   // Reference model: burst ownership as seen from the bus
   bit          mdl_busy, mdl_ar_done, mdl_last_d;
   logic [1:0]  mdl_owner;
   logic [31:0] mdl_addr;
   logic [3:0]  mdl_len, mdl_id;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int next_delay();
      return (ar_delay < 0) ? int'($urandom_range(0, 3)) : ar_delay;
   endfunction

   task automatic reset_tb_state();
      i_req_q.delete(); d_req_q.delete(); exp_q.delete();
      i_pres = 0; d_pres = 0; i_cool = 0; d_cool = 0;
      sl_data = 0; sl_beats = 0; sl_idx = 0; sl_wait = next_delay();
      mdl_busy = 0; mdl_ar_done = 0; mdl_last_d = 0; mdl_owner = 2'b00;
      mdl_addr = 32'd0; mdl_len = 4'd0; mdl_id = 4'd0;
   endtask

   task automatic check_reset_vals(input string ph);
      check({ph, "_i_arready"}, i_arready, 0);
      check({ph, "_d_arready"}, d_arready, 0);
      check({ph, "_m_arvalid"}, m_arvalid, 0);
      check({ph, "_m_rready"}, m_rready, 0);
      check({ph, "_i_rvalid"}, i_rvalid, 0);
      check({ph, "_d_rvalid"}, d_rvalid, 0);
      check({ph, "_owner"}, owner, 0);
      check({ph, "_m_araddr"}, m_araddr, 0);
      check({ph, "_m_arlen"}, m_arlen, 0);
      check({ph, "_m_arid"}, m_arid, 0);
   endtask

   task automatic drive_idle_inputs();
      i_arvalid = 0; i_araddr = 0; i_arlen = 0;
      d_arvalid = 0; d_araddr = 0; d_arlen = 0;
      m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0;
   endtask

   task automatic apply_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      drive_idle_inputs();
      reset_tb_state();
      repeat (2) @(negedge aclk);
      #1 check_reset_vals("rst");
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   // One clock: drive inputs after the falling edge, check, then advance model and agents.
   task automatic step();
      bit exp_gi, exp_gd, exp_ir, exp_dr;
      logic [39:0] e;
      @(negedge aclk);
      if (!i_pres) i_pres = (i_req_q.size() > 0) && !i_cool && (!rnd_mode || $urandom_range(0, 1) == 1);
      if (!d_pres) d_pres = (d_req_q.size() > 0) && !d_cool && (!rnd_mode || $urandom_range(0, 1) == 1);
      i_cool = 0;
      d_cool = 0;
      i_arvalid = i_pres;
      i_araddr  = i_pres ? i_req_q[0].addr : $urandom;
      i_arlen   = i_pres ? i_req_q[0].len  : 4'($urandom_range(0, 15));
      d_arvalid = d_pres;
      d_araddr  = d_pres ? d_req_q[0].addr : $urandom;
      d_arlen   = d_pres ? d_req_q[0].len  : 4'($urandom_range(0, 15));
      m_rdata = $urandom;
      if (sl_data) begin
         m_arready = 1'b0;
         m_rvalid  = ($urandom_range(1, 100) <= rv_pct);
         m_rlast   = m_rvalid ? (sl_beats == 1) : 1'($urandom_range(0, 1));
      end else begin
         m_arready = m_arvalid && (sl_wait == 0);
         m_rvalid  = junk_en && ($urandom_range(0, 3) == 0);
         m_rlast   = 1'($urandom_range(0, 1));
      end
      if (rst_beat && sl_data && m_rvalid && sl_idx == 2) begin
         aresetn = 1'b0;
         #1 check_reset_vals("midrst");
         reset_tb_state();
         rst_beat  = 0;
         rst_fired = 1;
         return;
      end
      #1;
      exp_gi = 0;
      exp_gd = 0;
      if (!mdl_busy) begin
         if (i_arvalid && d_arvalid) begin
            if (mdl_last_d) exp_gi = 1; else exp_gd = 1;
         end else if (i_arvalid) exp_gi = 1;
         else if (d_arvalid) exp_gd = 1;
      end
      exp_ir = mdl_busy && mdl_ar_done && (mdl_owner == 2'b01) && m_rvalid;
      exp_dr = mdl_busy && mdl_ar_done && (mdl_owner == 2'b10) && m_rvalid;
      check("i_arready", i_arready, exp_gi);
      check("d_arready", d_arready, exp_gd);
      check("m_arvalid", m_arvalid, mdl_busy && !mdl_ar_done);
      check("m_rready", m_rready, mdl_busy && mdl_ar_done);
      check("owner", owner, mdl_busy ? mdl_owner : 2'b00);
      check("m_araddr", m_araddr, mdl_addr);
      check("m_arlen", m_arlen, mdl_len);
      check("m_arid", m_arid, mdl_id);
      check("m_arsize", m_arsize, 3'b010);
      check("m_arburst", m_arburst, 2'b01);
      check("i_rvalid", i_rvalid, exp_ir);
      check("d_rvalid", d_rvalid, exp_dr);
      check("s_rdata", s_rdata, m_rdata);
      check("s_rlast", s_rlast, m_rlast);
      if (m_arvalid) obs_arv++;
      if (i_rvalid) obs_i++;
      if (d_rvalid) obs_d++;
      if (m_arvalid && m_arready) begin
         if (exp_q.size() == 0) check("ar_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("ar_hs_id", m_arid, e[39:36]);
            check("ar_hs_len", m_arlen, e[35:32]);
            check("ar_hs_addr", m_araddr, e[31:0]);
         end
      end
      // model
      if (exp_gi || exp_gd) begin
         mdl_busy    = 1;
         mdl_ar_done = 0;
         mdl_owner   = exp_gi ? 2'b01 : 2'b10;
         mdl_last_d  = exp_gd;
         mdl_addr    = exp_gi ? i_araddr : d_araddr;
         mdl_len     = exp_gi ? i_arlen : d_arlen;
         mdl_id      = exp_gi ? ICACHE_ID : DCACHE_ID;
         exp_q.push_back({mdl_id, mdl_len, mdl_addr});
         grant_log.push_back(exp_gi ? 0 : 1);
      end else if (mdl_busy && !mdl_ar_done && m_arready) begin
         mdl_ar_done = 1;
      end else if (mdl_busy && mdl_ar_done && m_rvalid && m_rlast) begin
         mdl_busy = 0;
      end
      // agents follow what the DUT actually did
      if (i_arvalid && i_arready && i_req_q.size() > 0) begin
         void'(i_req_q.pop_front()); i_pres = 0; i_cool = 1;
      end
      if (d_arvalid && d_arready && d_req_q.size() > 0) begin
         void'(d_req_q.pop_front()); d_pres = 0; d_cool = 1;
      end
      if (!sl_data && m_arvalid && m_arready) begin
         sl_data = 1; sl_beats = int'(m_arlen) + 1; sl_idx = 0;
      end else if (!sl_data && m_arvalid && sl_wait > 0) begin
         sl_wait--;
      end else if (sl_data && m_rvalid) begin
         sl_beats--; sl_idx++;
         if (sl_beats == 0) begin
            sl_data = 0; sl_wait = next_delay();
         end
      end
   endtask

   task automatic run_until_idle(input int max_cyc);
      int n = 0;
      bit busy;
      do begin
         step();
         n++;
         busy = (i_req_q.size() > 0) || (d_req_q.size() > 0) || mdl_busy || sl_data || i_pres || d_pres;
      end while (busy && n < max_cyc);
      check("drain_timeout", busy, 0);
   endtask

   task automatic clear_obs();
      obs_i = 0; obs_d = 0; obs_arv = 0;
      grant_log.delete();
   endtask

   initial begin
      automatic int tot_beats = 0;
      aresetn = 1'b0;
      drive_idle_inputs();
      reset_tb_state();
      apply_reset();

      // Tie right after reset, then continuous requests from both: d, i, d, i
      clear_obs();
      i_req_q.push_back('{addr: 32'h0000_1000, len: 4'd3});
      i_req_q.push_back('{addr: 32'h0000_2000, len: 4'd1});
      d_req_q.push_back('{addr: 32'h8000_0000, len: 4'd2});
      d_req_q.push_back('{addr: 32'h8000_0040, len: 4'd0});
      run_until_idle(400);
      check("alt_count", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         check("alt_g0", grant_log[0], 1);
         check("alt_g1", grant_log[1], 0);
         check("alt_g2", grant_log[2], 1);
         check("alt_g3", grant_log[3], 0);
      end
      check("alt_i_beats", obs_i, 6);
      check("alt_d_beats", obs_d, 4);

      // icache only, 8-beat fill
      clear_obs();
      i_req_q.push_back('{addr: 32'h1FC0_0000, len: 4'd7});
      run_until_idle(200);
      check("ic_i_beats", obs_i, 8);
      check("ic_d_beats", obs_d, 0);

      // AR held off for 5 cycles
      clear_obs();
      ar_delay = 5; sl_wait = 5;
      d_req_q.push_back('{addr: 32'h4000_0100, len: 4'd2});
      run_until_idle(200);
      check("ardly_arvalid_cycles", obs_arv, 6);
      check("ardly_d_beats", obs_d, 3);
      ar_delay = 0; sl_wait = 0;

      // dcache single beat with R gaps
      clear_obs();
      rv_pct = 25;
      d_req_q.push_back('{addr: 32'hBFAF_0000, len: 4'd0});
      run_until_idle(300);
      check("dc1_d_beats", obs_d, 1);
      check("dc1_i_beats", obs_i, 0);
      rv_pct = 100;

      // Reset on the third beat of an icache burst, then a normal grant
      clear_obs();
      rst_fired = 0;
      rst_beat  = 1;
      i_req_q.push_back('{addr: 32'h1FC0_0200, len: 4'd7});
      for (int n = 0; n < 200 && !rst_fired; n++) step();
      check("midrst_fired", rst_fired, 1);
      drive_idle_inputs();
      rst_beat = 0;
      @(negedge aclk);
      #1 check_reset_vals("midrst_hold");
      @(negedge aclk);
      aresetn = 1'b1;
      clear_obs();
      i_req_q.push_back('{addr: 32'h1FC0_0300, len: 4'd3});
      run_until_idle(200);
      check("postrst_grants", grant_log.size(), 1);
      check("postrst_i_beats", obs_i, 4);

      // Randomized traffic
      clear_obs();
      rnd_mode = 1; junk_en = 1; ar_delay = -1; rv_pct = 60;
      sl_wait = next_delay();
      for (int k = 0; k < 30; k++) begin
         req_t r;
         r.addr = $urandom; r.len = 4'($urandom_range(0, 15));
         i_req_q.push_back(r); tot_beats += int'(r.len) + 1;
         r.addr = $urandom; r.len = 4'($urandom_range(0, 15));
         d_req_q.push_back(r); tot_beats += int'(r.len) + 1;
      end
      run_until_idle(20000);
      check("rnd_grants", grant_log.size(), 60);
      check("rnd_beats", obs_i + obs_d, tot_beats);
      check("rnd_exp_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
